// File: rtl/vend_payment_collector.sv
// Vending payment collector: takes a selection, accumulates coins up to 99c,
// then hands money/price to a change dispenser and closes the transaction.
module vend_payment_collector (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   input  logic       sel_valid,
   input  logic [6:0] sel_price,
   input  logic       cancel,
   input  logic       disp_done,
   output logic [6:0] money,
   output logic [6:0] price,
   output logic       start,
   output logic       coin_reject,
   output logic       sel_error,
   output logic       vend,
   output logic       txn_done,
   output logic       busy,
   output logic       fault
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COLLECT   = 2'd1,
      LAUNCH    = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t     state;
   logic       refund;
   logic [3:0] timer;
   logic [6:0] coin_value;
   logic [6:0] sum;
   logic       price_legal;

   always_comb begin
      coin_value = 7'd0;
      case (coin_type)
         2'b00:   coin_value = 7'd25;
         2'b01:   coin_value = 7'd10;
         2'b10:   coin_value = 7'd5;
         default: coin_value = 7'd1;
      endcase
   end

   // 99 + 25 fits in 7 bits, so the sum never wraps before the cap check.
   assign sum         = money + coin_value;
   assign price_legal = (sel_price != 7'd0) && (sel_price <= 7'd99);
   assign busy        = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         money       <= 7'd0;
         price       <= 7'd0;
         refund      <= 1'b0;
         timer       <= 4'd0;
         start       <= 1'b0;
         coin_reject <= 1'b0;
         sel_error   <= 1'b0;
         vend        <= 1'b0;
         txn_done    <= 1'b0;
         fault       <= 1'b0;
      end else begin
         coin_reject <= 1'b0;
         sel_error   <= 1'b0;
         vend        <= 1'b0;
         txn_done    <= 1'b0;
         case (state)
            IDLE: begin
               money       <= 7'd0;
               price       <= 7'd0;
               start       <= 1'b0;
               refund      <= 1'b0;
               timer       <= 4'd0;
               coin_reject <= coin_valid;
               if (sel_valid) begin
                  if (price_legal) begin
                     price <= sel_price;
                     state <= COLLECT;
                  end else begin
                     sel_error <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (money >= price) begin
                  // Paid in full: any coin arriving now goes back.
                  coin_reject <= coin_valid;
                  start       <= 1'b1;
                  timer       <= 4'd0;
                  state       <= LAUNCH;
               end else begin
                  if (coin_valid) begin
                     if (sum <= 7'd99) money <= sum;
                     else              coin_reject <= 1'b1;
                  end
                  if (cancel) begin
                     refund <= 1'b1;
                     price  <= 7'd0;
                     start  <= 1'b1;
                     timer  <= 4'd0;
                     state  <= LAUNCH;
                  end
               end
            end
            LAUNCH: begin
               coin_reject <= coin_valid;
               if (!disp_done) begin
                  start <= 1'b0;
                  state <= WAIT_DONE;
               end else if (timer == 4'd14) begin
                  // Fifteenth cycle with the dispenser never acknowledging.
                  fault  <= 1'b1;
                  start  <= 1'b0;
                  money  <= 7'd0;
                  price  <= 7'd0;
                  refund <= 1'b0;
                  timer  <= 4'd0;
                  state  <= IDLE;
               end else begin
                  timer <= timer + 4'd1;
               end
            end
            WAIT_DONE: begin
               coin_reject <= coin_valid;
               start       <= 1'b0;
               if (disp_done) begin
                  txn_done <= 1'b1;
                  vend     <= ~refund;
                  money    <= 7'd0;
                  price    <= 7'd0;
                  refund   <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vend_payment_collector.sv
// Directed bench for vend_payment_collector with hand-computed expectations.
module tb_vend_payment_collector;

   logic       clk = 1'b0;
   logic       reset;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic       sel_valid;
   logic [6:0] sel_price;
   logic       cancel;
   logic       disp_done;
   logic [6:0] money;
   logic [6:0] price;
   logic       start;
   logic       coin_reject;
   logic       sel_error;
   logic       vend;
   logic       txn_done;
   logic       busy;
   logic       fault;

   int total = 0;
   int bad   = 0;

   localparam logic [1:0] C25 = 2'b00, C10 = 2'b01, C5 = 2'b10, C1 = 2'b11;

   vend_payment_collector dut (
      .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
      .sel_valid(sel_valid), .sel_price(sel_price), .cancel(cancel),
      .disp_done(disp_done), .money(money), .price(price), .start(start),
      .coin_reject(coin_reject), .sel_error(sel_error), .vend(vend),
      .txn_done(txn_done), .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
      coin_type = C25; sel_price = 7'd0;
   endtask

   task automatic select(input logic [6:0] p);
      sel_valid = 1'b1; sel_price = p;
      step();
      sel_valid = 1'b0;
   endtask

   task automatic coin(input logic [1:0] t);
      coin_valid = 1'b1; coin_type = t;
      step();
      coin_valid = 1'b0;
   endtask

   initial begin
      idle_inputs();
      disp_done = 1'b1;
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      chk("rst_money", {1'b0, money}, 8'd0);
      chk("rst_price", {1'b0, price}, 8'd0);
      chk("rst_outs", {2'b0, start, coin_reject, sel_error, vend, txn_done, busy}, 8'd0);
      chk("rst_fault", {7'b0, fault}, 8'd0);

      // sel 65c, coins 25,25,10,5
      select(7'd65);
      chk("t1_busy", {7'b0, busy}, 8'd1);
      chk("t1_price", {1'b0, price}, 8'd65);
      coin(C25); coin(C25); coin(C10); coin(C5);
      chk("t1_money", {1'b0, money}, 8'd65);
      step();
      chk("t1_start", {7'b0, start}, 8'd1);
      step();
      chk("t1_start_held", {7'b0, start}, 8'd1);
      disp_done = 1'b0; step();
      chk("t1_start_drop", {7'b0, start}, 8'd0);
      chk("t1_wait_busy", {7'b0, busy}, 8'd1);
      disp_done = 1'b1; step();
      chk("t1_vend", {7'b0, vend}, 8'd1);
      chk("t1_txn", {7'b0, txn_done}, 8'd1);
      chk("t1_idle", {7'b0, busy}, 8'd0);
      step();
      chk("t1_vend_pulse", {6'b0, vend, txn_done}, 8'd0);
      $display("txn t1 sel65 money=%0d", money);

      // sel 40c, coins 25,25; stray selection during collect is ignored
      select(7'd40);
      coin(C25);
      sel_valid = 1'b1; sel_price = 7'd0; coin(C25); sel_valid = 1'b0;
      chk("t2_no_selerr", {7'b0, sel_error}, 8'd0);
      chk("t2_money", {1'b0, money}, 8'd50);
      step();
      chk("t2_price", {1'b0, price}, 8'd40);
      chk("t2_start", {7'b0, start}, 8'd1);
      disp_done = 1'b0; step(); step();
      chk("t2_money_stable", {1'b0, money}, 8'd50);
      chk("t2_vend_early", {7'b0, vend}, 8'd0);
      disp_done = 1'b1; step();
      chk("t2_vend", {7'b0, vend}, 8'd1);
      $display("txn t2 sel40 vend=%0d", vend);

      // 99c cap: fourth quarter at 75 would make 100 and is rejected
      select(7'd99);
      coin(C25); coin(C25); coin(C25);
      coin(C25);
      chk("t3_reject", {7'b0, coin_reject}, 8'd1);
      chk("t3_money", {1'b0, money}, 8'd75);
      step();
      chk("t3_reject_pulse", {7'b0, coin_reject}, 8'd0);
      cancel = 1'b1; coin(C1); cancel = 1'b0;
      chk("t3_cancel_money", {1'b0, money}, 8'd76);
      chk("t3_cancel_price", {1'b0, price}, 8'd0);
      chk("t3_cancel_start", {7'b0, start}, 8'd1);
      disp_done = 1'b0; step();
      disp_done = 1'b1; step();
      chk("t3_txn", {6'b0, vend, txn_done}, 8'd1);
      $display("txn t3 cap cancel done");

      // sel 50c, coins 10,5, cancel
      select(7'd50);
      coin(C10); coin(C5);
      cancel = 1'b1; step(); cancel = 1'b0;
      chk("t4_price", {1'b0, price}, 8'd0);
      chk("t4_money", {1'b0, money}, 8'd15);
      disp_done = 1'b0; step();
      disp_done = 1'b1; step();
      chk("t4_vend", {7'b0, vend}, 8'd0);
      chk("t4_txn", {7'b0, txn_done}, 8'd1);
      $display("txn t4 refund money=15");

      // illegal selections and a coin in IDLE
      select(7'd0);
      chk("t5_selerr0", {7'b0, sel_error}, 8'd1);
      chk("t5_busy0", {7'b0, busy}, 8'd0);
      select(7'd120);
      chk("t5_selerr120", {7'b0, sel_error}, 8'd1);
      chk("t5_busy120", {7'b0, busy}, 8'd0);
      step();
      chk("t5_selerr_pulse", {7'b0, sel_error}, 8'd0);
      coin(C10);
      chk("t5_idle_reject", {7'b0, coin_reject}, 8'd1);
      chk("t5_idle_money", {1'b0, money}, 8'd0);
      $display("txn t5 illegal selections");

      // dispenser never drops done: timeout fault
      select(7'd10);
      coin(C10);
      step();
      chk("t6_start", {7'b0, start}, 8'd1);
      for (int i = 0; i < 14; i++) step();
      chk("t6_still_launch", {6'b0, start, fault}, 8'd2);
      step();
      chk("t6_fault", {7'b0, fault}, 8'd1);
      chk("t6_start_drop", {7'b0, start}, 8'd0);
      chk("t6_idle", {7'b0, busy}, 8'd0);
      chk("t6_no_txn", {6'b0, vend, txn_done}, 8'd0);
      chk("t6_money_clr", {1'b0, money}, 8'd0);
      $display("txn t6 timeout fault=%0d", fault);

      // fault does not block; reset mid-WAIT_DONE aborts and clears fault
      select(7'd5);
      coin(C5);
      step();
      disp_done = 1'b0; step();
      chk("t7_wait", {7'b0, busy}, 8'd1);
      reset = 1'b1; disp_done = 1'b1; step(); reset = 1'b0;
      chk("t7_rst_fault", {7'b0, fault}, 8'd0);
      chk("t7_rst_outs", {2'b0, start, coin_reject, sel_error, vend, txn_done, busy}, 8'd0);
      chk("t7_rst_money", {1'b0, money}, 8'd0);
      $display("txn t7 reset abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
